// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable latency, big-endian
// byte-addressed array held as four byte lanes, zero-extended right-justified loads.
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [0:31] req_addr,
  input  logic [0:31] req_wdata,
  input  logic [0:1]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [0:31] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam int WORDS    = 1 << IDX_BITS;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              stateReg;
  logic [3:0]          cntReg;
  logic                reqReadyReg;
  logic                respValidReg;
  logic                errReg;
  logic                loadOkReg;
  logic                writeReg;
  logic [IDX_BITS-1:0] idxReg;
  logic [1:0]          offReg;
  logic [1:0]          sizeReg;
  logic [0:31]         wdataReg;

  logic                curWrite;
  logic [IDX_BITS-1:0] curIdx;
  logic [1:0]          curOff;
  logic [1:0]          curSize;
  logic [0:31]         curWdata;
  logic                curErr;
  logic                enterResp;
  logic [0:31]         laneWord;
  logic                unusedAddrBits;

  // Upper address bits alias onto the array.
  assign unusedAddrBits = ^req_addr[0:31-ADDR_BITS];

  // In IDLE the live request is used so that LATENCY=1 can commit at the acceptance edge.
  always_comb begin
    curWrite  = writeReg;
    curIdx    = idxReg;
    curOff    = offReg;
    curSize   = sizeReg;
    curWdata  = wdataReg;
    if (stateReg == IDLE) begin
      curWrite = req_write;
      curIdx   = req_addr[32-ADDR_BITS:29];
      curOff   = req_addr[30:31];
      curSize  = req_size;
      curWdata = req_wdata;
    end
    curErr = (curSize == 2'b11) ||
             (curSize == 2'b01 && curOff[0]) ||
             (curSize == 2'b10 && curOff != 2'b00);
    enterResp = (stateReg == IDLE && req_valid && LATENCY == 1) ||
                (stateReg == BUSY && cntReg == 4'd0);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    localparam logic [1:0] LANE = 2'(gi);
    logic [7:0] mem [WORDS];
    logic [7:0] rdQ;
    logic [7:0] wd;
    logic       we;

    always_comb begin
      we = 1'b0;
      wd = curWdata[24:31];
      case (curSize)
        2'b00: we = (curOff == LANE);
        2'b01: begin
          we = (curOff[1] == LANE[1]);
          wd = LANE[0] ? curWdata[24:31] : curWdata[16:23];
        end
        2'b10: begin
          we = 1'b1;
          wd = curWdata[8*gi +: 8];
        end
        default: we = 1'b0;
      endcase
      we = we & enterResp & curWrite & ~curErr;
    end

    always_ff @(posedge clk) begin
      if (we)
        mem[curIdx] <= wd;
      if (enterResp)
        rdQ <= mem[curIdx];
    end

    assign laneWord[8*gi +: 8] = rdQ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg     <= IDLE;
      cntReg       <= 4'd0;
      reqReadyReg  <= 1'b1;
      respValidReg <= 1'b0;
      errReg       <= 1'b0;
      loadOkReg    <= 1'b0;
      writeReg     <= 1'b0;
      idxReg       <= '0;
      offReg       <= 2'b00;
      sizeReg      <= 2'b00;
      wdataReg     <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (req_valid) begin
            writeReg    <= req_write;
            idxReg      <= curIdx;
            offReg      <= curOff;
            sizeReg     <= curSize;
            wdataReg    <= req_wdata;
            reqReadyReg <= 1'b0;
            stateReg    <= BUSY;
            cntReg      <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cntReg != 4'd0)
            cntReg <= cntReg - 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            stateReg     <= IDLE;
            reqReadyReg  <= 1'b1;
            respValidReg <= 1'b0;
            errReg       <= 1'b0;
            loadOkReg    <= 1'b0;
          end
        end
        default: stateReg <= IDLE;
      endcase
      if (enterResp) begin
        stateReg     <= RESP;
        respValidReg <= 1'b1;
        errReg       <= curErr;
        loadOkReg    <= ~curWrite & ~curErr;
      end
    end
  end

  always_comb begin
    resp_rdata = '0;
    if (respValidReg && loadOkReg) begin
      case (sizeReg)
        2'b00:   resp_rdata[24:31] = laneWord[{offReg, 3'b000} +: 8];
        2'b01:   resp_rdata[16:31] = laneWord[{offReg, 3'b000} +: 16];
        default: resp_rdata        = laneWord;
      endcase
    end
  end

  assign req_ready  = reqReadyReg;
  assign resp_valid = respValidReg;
  assign resp_err   = errReg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances (LATENCY 2, 3, 1, 15) driven by tasks.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst        [4];
  logic        reqValid   [4];
  logic        reqReady   [4];
  logic        reqWrite   [4];
  logic [0:31] reqAddr    [4];
  logic [0:31] reqWdata   [4];
  logic [0:1]  reqSize    [4];
  logic        respValid  [4];
  logic        respReady  [4];
  logic [0:31] respRdata  [4];
  logic        respErr    [4];

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : gDut
    dmem_responder #(
      .ADDR_BITS(10),
      .LATENCY(gi == 0 ? 2 : gi == 1 ? 3 : gi == 2 ? 1 : 15)
    ) dut (
      .clk       (clk),
      .reset     (rst[gi]),
      .req_valid (reqValid[gi]),
      .req_ready (reqReady[gi]),
      .req_write (reqWrite[gi]),
      .req_addr  (reqAddr[gi]),
      .req_wdata (reqWdata[gi]),
      .req_size  (reqSize[gi]),
      .resp_valid(respValid[gi]),
      .resp_ready(respReady[gi]),
      .resp_rdata(respRdata[gi]),
      .resp_err  (respErr[gi])
    );
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic waitReady(input int k);
    int guard = 0;
    while (!reqReady[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!reqReady[k])
      check("req_ready_timeout", 32'(reqReady[k]), 32'd1);
  endtask

  task automatic waitResp(input int k, output int lat);
    lat = 1;
    while (!respValid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full handshake; request inputs are scrambled after acceptance to prove they are latched.
  task automatic doReq(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, output logic [31:0] rdata, output logic err,
                       output int lat);
    @(negedge clk);
    reqWrite[k]  = wr;
    reqAddr[k]   = addr;
    reqWdata[k]  = wdata;
    reqSize[k]   = size;
    reqValid[k]  = 1'b1;
    respReady[k] = 1'b1;
    waitReady(k);
    @(posedge clk);
    @(negedge clk);
    reqValid[k] = 1'b0;
    reqWrite[k] = ~wr;
    reqAddr[k]  = ~addr;
    reqWdata[k] = ~wdata;
    reqSize[k]  = ~size;
    waitResp(k, lat);
    rdata = respRdata[k];
    err   = respErr[k];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    logic        er;
    int          lat;
    int          lats [4] = '{2, 3, 1, 15};

    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,        2'b10, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h10, 32'h0,        2'b00, 32'h000000DE, 1'b0};
    vecs[3]  = '{1'b0, 32'h11, 32'h0,        2'b00, 32'h000000AD, 1'b0};
    vecs[4]  = '{1'b0, 32'h12, 32'h0,        2'b00, 32'h000000BE, 1'b0};
    vecs[5]  = '{1'b0, 32'h13, 32'h0,        2'b00, 32'h000000EF, 1'b0};
    vecs[6]  = '{1'b0, 32'h12, 32'h0,        2'b01, 32'h0000BEEF, 1'b0};
    vecs[7]  = '{1'b1, 32'h11, 32'h00000055, 2'b00, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h10, 32'h0,        2'b10, 32'hDE55BEEF, 1'b0};
    vecs[9]  = '{1'b0, 32'h11, 32'h0,        2'b01, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h10, 32'h0,        2'b10, 32'hDE55BEEF, 1'b0};
    vecs[11] = '{1'b1, 32'h12, 32'hFFFFFFFF, 2'b10, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h10, 32'h0,        2'b10, 32'hDE55BEEF, 1'b0};
    vecs[13] = '{1'b1, 32'h10, 32'h0,        2'b11, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 32'h10, 32'h0,        2'b10, 32'hDE55BEEF, 1'b0};
    vecs[15] = '{1'b1, 32'h12, 32'hCAFE1234, 2'b01, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 32'h10, 32'h0,        2'b10, 32'hDE551234, 1'b0};

    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; reqValid[k] = 1'b0; reqWrite[k] = 1'b0; reqAddr[k] = '0;
      reqWdata[k] = '0; reqSize[k] = '0; respReady[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_req_ready[%0d]", k), 32'(reqReady[k]), 32'd1);
      check($sformatf("reset_resp_valid[%0d]", k), 32'(respValid[k]), 32'd0);
      check($sformatf("reset_resp_rdata[%0d]", k), respRdata[k], 32'd0);
      check($sformatf("reset_resp_err[%0d]", k), 32'(respErr[k]), 32'd0);
    end

    for (int i = 0; i < 17; i++) begin
      doReq(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, rd, er, lat);
      $display("vec %0d: wr=%0d addr=%h size=%0d rdata=%h err=%0d lat=%0d",
               i, vecs[i].wr, vecs[i].addr, vecs[i].size, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].expData);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].expErr));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Backpressure: response held 5 cycles while a competing request waits.
    @(negedge clk);
    reqWrite[0] = 1'b0; reqAddr[0] = 32'h10; reqSize[0] = 2'b10;
    reqValid[0] = 1'b1; respReady[0] = 1'b0;
    waitReady(0);
    @(posedge clk);
    @(negedge clk);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqWdata[0] = 32'h11111111;
    waitResp(0, lat);
    check("bp_latency", 32'(lat), 32'd2);
    held = respRdata[0];
    check("bp_rdata", held, 32'hDE551234);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", c), 32'(respValid[0]), 32'd1);
      check($sformatf("bp_rdata_c%0d", c), respRdata[0], held);
      check($sformatf("bp_req_ready_c%0d", c), 32'(reqReady[0]), 32'd0);
    end
    respReady[0] = 1'b1;
    @(negedge clk);
    check("bp_released_valid", 32'(respValid[0]), 32'd0);
    check("bp_released_ready", 32'(reqReady[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid[0] = 1'b0;
    waitResp(0, lat);
    check("bp_next_latency", 32'(lat), 32'd2);
    check("bp_next_err", 32'(respErr[0]), 32'd0);
    doReq(0, 1'b0, 32'h10, 32'h0, 2'b10, rd, er, lat);
    $display("bp readback: rdata=%h err=%0d lat=%0d", rd, er, lat);
    check("bp_readback", rd, 32'h11111111);

    // Reset one cycle after accepting a store (LATENCY=3): the store is dropped.
    doReq(1, 1'b1, 32'h20, 32'hAAAAAAAA, 2'b10, rd, er, lat);
    $display("rst setup store: lat=%0d", lat);
    check("rst_setup_latency", 32'(lat), 32'd3);
    @(negedge clk);
    reqWrite[1] = 1'b1; reqAddr[1] = 32'h20; reqWdata[1] = 32'h12345678;
    reqSize[1] = 2'b10; reqValid[1] = 1'b1;
    waitReady(1);
    @(posedge clk);
    @(negedge clk);
    reqValid[1] = 1'b0;
    @(posedge clk);
    #1 rst[1] = 1'b1;
    #1;
    check("rst_req_ready", 32'(reqReady[1]), 32'd1);
    check("rst_resp_valid", 32'(respValid[1]), 32'd0);
    check("rst_resp_rdata", respRdata[1], 32'd0);
    check("rst_resp_err", 32'(respErr[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    doReq(1, 1'b0, 32'h20, 32'h0, 2'b10, rd, er, lat);
    $display("rst readback: rdata=%h lat=%0d", rd, lat);
    check("rst_dropped_store", rd, 32'hAAAAAAAA);
    check("rst_readback_latency", 32'(lat), 32'd3);

    // Reset during a held response drops resp_valid without a clock edge.
    @(negedge clk);
    reqWrite[1] = 1'b0; reqAddr[1] = 32'h20; reqSize[1] = 2'b10;
    reqValid[1] = 1'b1; respReady[1] = 1'b0;
    waitReady(1);
    @(posedge clk);
    @(negedge clk);
    reqValid[1] = 1'b0;
    waitResp(1, lat);
    check("async_pre_valid", 32'(respValid[1]), 32'd1);
    #1 rst[1] = 1'b1;
    #1;
    $display("async reset: valid=%0d rdata=%h", respValid[1], respRdata[1]);
    check("async_resp_valid", 32'(respValid[1]), 32'd0);
    check("async_resp_rdata", respRdata[1], 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0; respReady[1] = 1'b1;

    // Latency sweep (1 and 15) with ADDR_BITS=10 aliasing.
    for (int k = 2; k < 4; k++) begin
      doReq(k, 1'b1, 32'h0000_0404, 32'hCAFEF00D, 2'b10, rd, er, lat);
      $display("sweep L=%0d store @404: lat=%0d err=%0d", lats[k], lat, er);
      check($sformatf("sweep%0d_store_lat", k), 32'(lat), 32'(lats[k]));
      doReq(k, 1'b0, 32'h0000_0004, 32'h0, 2'b10, rd, er, lat);
      $display("sweep L=%0d load @004: rdata=%h lat=%0d", lats[k], rd, lat);
      check($sformatf("sweep%0d_alias_rdata", k), rd, 32'hCAFEF00D);
      check($sformatf("sweep%0d_load_lat", k), 32'(lat), 32'(lats[k]));
      doReq(k, 1'b1, 32'h0000_0007, 32'h00000099, 2'b00, rd, er, lat);
      doReq(k, 1'b0, 32'h0000_0006, 32'h0, 2'b01, rd, er, lat);
      $display("sweep L=%0d half @006: rdata=%h lat=%0d", lats[k], rd, lat);
      check($sformatf("sweep%0d_half_rdata", k), rd, 32'h0000F099);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
